instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 119 +++++++++++
 tb/tb_instr_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a small program store, then fetches and issues words to a datapath
// until a HALT opcode or the last address. Optional abort input is enabled by the SEQ_ABORT_EN macro.
module instr_sequencer #(
    parameter int          INSTR_W    = 12,
    parameter int          PROG_DEPTH = 16,
    parameter logic [2:0]  HALT_OP    = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic               prog_we,
    input  logic [3:0]         prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               dp_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [3:0]         pc,
    output logic               busy,
    output logic               done,
    output logic [4:0]         issue_count
);

    localparam int         AW      = 4;
    localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);
    localparam logic [4:0] CNT_MAX = 5'd16;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [INSTR_W-1:0] mem_q [PROG_DEPTH];

    logic [INSTR_W-1:0] rd_word;
    logic               is_halt;
    logic               xfer;
    logic               abort_req;

    assign rd_word = mem_q[pc_q];
    assign is_halt = (rd_word[INSTR_W-1 -: 3] == HALT_OP);
    assign xfer    = (state_q == ISSUE) && dp_ready;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // Program store has no reset so a program survives rst; writes only land while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE)
            mem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = is_halt ? DONE : ISSUE;
            ISSUE: if (dp_ready) state_d = (pc_q == PC_LAST) ? DONE : FETCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_req)
            state_d = IDLE;
    end

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        if (state_q == IDLE && start) begin
            pc_d  = '0;
            cnt_d = '0;
        end
        if (state_q == FETCH)
            instr_d = rd_word;
        // The last address ends the run without wrapping pc.
        if (xfer) begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 5'd1;
            if (pc_q != PC_LAST)
                pc_d = pc_q + 4'd1;
        end
        if (abort_req) begin
            pc_d    = pc_q;
            cnt_d   = cnt_q;
            instr_d = instr_q;
        end
    end

    always_comb begin
        instr_valid = (state_q == ISSUE);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        instruction = instr_q;
        pc          = pc_q;
        issue_count = cnt_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued at start and
// compared against every transfer the DUT makes.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic        dp_ready = 1'b0;
    logic [11:0] instruction;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [4:0]  issue_count;
`ifdef SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    instr_sequencer dut (
        .clk(clk), .rst(rst),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dp_ready(dp_ready), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] pc; logic [11:0] instr; } exp_t;
    exp_t        sb[$];
    logic [11:0] tb_mem [16];
    int          total = 0;
    int          bad = 0;
    int          exp_cnt;
    logic [3:0]  exp_pc;

    // Sample transfers at negedge (inputs are stable then), then step to just after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst && instr_valid) begin
            total++;
            if (instruction[11:9] === 3'b111) begin
                bad++;
                $display("FAIL halt_valid: instruction=%h presented valid", instruction);
            end
        end
        if (!rst && instr_valid && dp_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got pc=%0d instr=%h, expected no transfer", pc, instruction);
            end else begin
                e = sb.pop_front();
                if (instruction !== e.instr || pc !== e.pc) begin
                    bad++;
                    $display("FAIL sb_issue: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             pc, instruction, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tb_mem[a] = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Reference walk of the model store: what a run should issue and where pc ends.
    task automatic push_run();
        exp_t e;
        exp_cnt = 0;
        exp_pc  = 4'd15;
        for (int a = 0; a < 16; a++) begin
            if (tb_mem[a][11:9] == 3'b111) begin
                exp_pc = 4'(a);
                break;
            end
            e.pc = 4'(a); e.instr = tb_mem[a];
            sb.push_back(e);
            exp_cnt++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_run();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
    endtask

    task automatic load_basic();
        load(4'd0, 12'b000000111100);
        load(4'd1, 12'b000001001111);
        load(4'd2, 12'b001000001010);
        load(4'd3, 12'b111000000000);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({instruction, instr_valid, pc, busy, done, issue_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: instr=%h v=%b pc=%0d busy=%b done=%b cnt=%0d, expected all 0",
                     instruction, instr_valid, pc, busy, done, issue_count);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit seen;
        load_basic();
        dp_ready = 1'b1;
        pulse_start();
        total++;
        if (busy !== 1'b1 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_fetch: busy=%b valid=%b, expected busy=1 valid=0", busy, instr_valid);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instruction !== 12'b000000111100 || pc !== 4'd0) begin
            bad++;
            $display("FAIL basic_first: valid=%b instr=%h pc=%0d, expected 1 03c 0", instr_valid, instruction, pc);
        end
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd3 || pc !== 4'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL basic_done: seen=%b cnt=%0d pc=%0d left=%0d, expected 1 3 3 0",
                     seen, issue_count, pc, sb.size());
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || issue_count !== 5'd3 || pc !== 4'd3) begin
            bad++;
            $display("FAIL basic_after: done=%b busy=%b cnt=%0d pc=%0d, expected 0 0 3 3",
                     done, busy, issue_count, pc);
        end
    endtask

    task automatic test_stall();
        bit seen;
        int guard;
        dp_ready = 1'b1;
        pulse_start();
        guard = 0;
        while (!(instr_valid && pc == 4'd1) && guard < 50) begin tick(); guard++; end
        dp_ready = 1'b0;
        total++;
        if (guard >= 50) begin
            bad++;
            $display("FAIL stall_reach: timeout, expected ISSUE at pc 1");
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instruction !== 12'b000001001111 || issue_count !== 5'd1) begin
                bad++;
                $display("FAIL stall_hold: valid=%b instr=%h cnt=%0d, expected 1 04f 1",
                         instr_valid, instruction, issue_count);
            end
        end
        dp_ready = 1'b1;
        tick();
        total++;
        if (issue_count !== 5'd2) begin
            bad++;
            $display("FAIL stall_xfer: cnt=%0d, expected 2", issue_count);
        end
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL stall_done: seen=%b cnt=%0d left=%0d, expected 1 3 0", seen, issue_count, sb.size());
        end
        tick();
    endtask

    task automatic test_wr_start();
        bit seen;
        dp_ready = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 12'b010101010101;
        tb_mem[0] = 12'b010101010101;
        pulse_start();
        prog_we = 1'b0;
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL wr_start: seen=%b cnt=%0d left=%0d, expected 1 3 0", seen, issue_count, sb.size());
        end
        tick();
    endtask

    task automatic test_full();
        bit seen;
        logic [11:0] w;
        for (int a = 0; a < 16; a++) begin
            w = 12'($urandom);
            w[11:9] = 3'($urandom_range(0, 6));
            load(4'(a), w);
        end
        dp_ready = 1'b1;
        pulse_start();
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd16 || pc !== 4'd15 || sb.size() != 0) begin
            bad++;
            $display("FAIL full_done: seen=%b cnt=%0d pc=%0d left=%0d, expected 1 16 15 0",
                     seen, issue_count, pc, sb.size());
        end
        tick();
        total++;
        if (busy !== 1'b0 || pc !== 4'd15 || issue_count !== 5'd16) begin
            bad++;
            $display("FAIL full_hold: busy=%b pc=%0d cnt=%0d, expected 0 15 16", busy, pc, issue_count);
        end
    endtask

    task automatic test_busy_ignore();
        bit seen;
        dp_ready = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        // HALT data at address 1 would cut the re-run short if this write were taken.
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 12'hE00;
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd16 || sb.size() != 0) begin
            bad++;
            $display("FAIL busy_run: seen=%b cnt=%0d left=%0d, expected 1 16 0", seen, issue_count, sb.size());
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_ignored: busy=%b, expected 0", busy);
        end
        pulse_start();
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd16 || sb.size() != 0) begin
            bad++;
            $display("FAIL busy_rerun: seen=%b cnt=%0d left=%0d, expected 1 16 0", seen, issue_count, sb.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        int guard;
        load_basic();
        dp_ready = 1'b0;
        pulse_start();
        guard = 0;
        while (!instr_valid && guard < 20) begin tick(); guard++; end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({instruction, instr_valid, pc, busy, done, issue_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: instr=%h v=%b pc=%0d busy=%b done=%b cnt=%0d, expected all 0",
                     instruction, instr_valid, pc, busy, done, issue_count);
        end
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        dp_ready = 1'b1;
        pulse_start();
        wait_done(seen);
        total++;
        if (!seen || issue_count !== 5'd3 || pc !== 4'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL reset_rerun: seen=%b cnt=%0d pc=%0d left=%0d, expected 1 3 3 0",
                     seen, issue_count, pc, sb.size());
        end
        tick();
    endtask

`ifdef SEQ_ABORT_EN
    task automatic test_abort();
        int guard;
        dp_ready = 1'b1;
        pulse_start();
        guard = 0;
        while (!(instr_valid && pc == 4'd1) && guard < 50) begin tick(); guard++; end
        dp_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        total++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0 || issue_count !== 5'd1 || pc !== 4'd1) begin
            bad++;
            $display("FAIL abort_idle: busy=%b v=%b done=%b cnt=%0d pc=%0d, expected 0 0 0 1 1",
                     busy, instr_valid, done, issue_count, pc);
        end
        tick();
        total++;
        if (done !== 1'b0 || issue_count !== 5'd1) begin
            bad++;
            $display("FAIL abort_nodone: done=%b cnt=%0d, expected 0 1", done, issue_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wr_start();
        test_full();
        test_busy_ignore();
        test_reset_mid();
`ifdef SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
